// File: rtl/md_seq_ctrl.sv
// Sequencing controller for the RV32M multiply/divide unit: accepts one op from the
// reservation station, drives the shared sequential datapath and holds the result for the CDB.
module md_seq_ctrl #(
    parameter int PRF_IDX_W = 6,
    parameter int ROB_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 iss_valid,
    output logic                 iss_ready,
    input  logic [2:0]           iss_funct3,
    input  logic [31:0]          iss_rs1,
    input  logic [31:0]          iss_rs2,
    input  logic [PRF_IDX_W-1:0] iss_pd,
    input  logic [ROB_IDX_W-1:0] iss_rob,
    output logic                 mul_start,
    output logic                 div_start,
    output logic [31:0]          dp_a,
    output logic [31:0]          dp_b,
    output logic                 dp_tc,
    input  logic                 mul_complete,
    input  logic [63:0]          mul_product,
    input  logic                 div_complete,
    input  logic [31:0]          div_quotient,
    input  logic [31:0]          div_remainder,
    output logic                 cdb_valid,
    input  logic                 cdb_ready,
    output logic [PRF_IDX_W-1:0] cdb_pd,
    output logic [ROB_IDX_W-1:0] cdb_rob,
    output logic [31:0]          cdb_data
);

    // state  | meaning
    // IDLE   | no op held, ready to accept
    // MUL    | multiplier running, waiting for mul_complete
    // DIV    | divider running, waiting for div_complete
    // DONE   | result held on the CDB until cdb_ready
    // DRAIN  | op flushed, waiting for the busy unit to finish
    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  funct3_q;
    logic        neg_q;
    logic        accept;
    logic        is_div, div_zero, div_ovf, special;
    logic [31:0] special_res;
    logic [31:0] rs1_abs;
    logic [63:0] prod_adj;
    logic [31:0] mul_res, div_res;

    assign is_div   = iss_funct3[2];
    assign div_zero = is_div && (iss_rs2 == 32'd0);
    // Only the signed forms (DIV/REM have funct3[0]=0) can overflow.
    assign div_ovf  = is_div && !iss_funct3[0] &&
                      (iss_rs1 == 32'h8000_0000) && (iss_rs2 == 32'hFFFF_FFFF);
    assign special  = div_zero || div_ovf;
    assign rs1_abs  = iss_rs1[31] ? (32'd0 - iss_rs1) : iss_rs1;

    always_comb begin
        special_res = 32'd0;
        if (div_zero) begin
            special_res = iss_funct3[1] ? iss_rs1 : 32'hFFFF_FFFF;
        end else if (div_ovf) begin
            special_res = iss_funct3[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // MULHSU runs unsigned on |rs1|; the sign is restored on the full 64-bit product.
    assign prod_adj = neg_q ? (64'd0 - mul_product) : mul_product;
    assign mul_res  = (funct3_q[1:0] == 2'b00) ? prod_adj[31:0] : prod_adj[63:32];
    assign div_res  = funct3_q[1] ? div_remainder : div_quotient;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        iss_ready = 1'b0;
        cdb_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                iss_ready = 1'b1;
                if (!flush && iss_valid) begin
                    accept    = 1'b1;
                    state_nxt = special ? S_DONE : (is_div ? S_DIV : S_MUL);
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_nxt = mul_complete ? S_IDLE : S_DRAIN;
                end else if (mul_complete) begin
                    state_nxt = S_DONE;
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_nxt = div_complete ? S_IDLE : S_DRAIN;
                end else if (div_complete) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                cdb_valid = 1'b1;
                iss_ready = cdb_ready;
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (cdb_ready) begin
                    if (iss_valid) begin
                        accept    = 1'b1;
                        state_nxt = special ? S_DONE : (is_div ? S_DIV : S_MUL);
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (funct3_q[2] ? div_complete : mul_complete) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_q  <= 3'd0;
            neg_q     <= 1'b0;
            mul_start <= 1'b0;
            div_start <= 1'b0;
            dp_a      <= 32'd0;
            dp_b      <= 32'd0;
            dp_tc     <= 1'b0;
            cdb_pd    <= '0;
            cdb_rob   <= '0;
            cdb_data  <= 32'd0;
        end else begin
            mul_start <= 1'b0;
            div_start <= 1'b0;
            if (accept) begin
                funct3_q <= iss_funct3;
                cdb_pd   <= iss_pd;
                cdb_rob  <= iss_rob;
                neg_q    <= 1'b0;
                dp_a     <= iss_rs1;
                dp_b     <= iss_rs2;
                if (special) begin
                    cdb_data <= special_res;
                end else if (is_div) begin
                    div_start <= 1'b1;
                    dp_tc     <= ~iss_funct3[0];
                end else begin
                    mul_start <= 1'b1;
                    dp_tc     <= ~iss_funct3[1];
                    if (iss_funct3 == 3'b010) begin
                        neg_q <= iss_rs1[31];
                        dp_a  <= rs1_abs;
                    end
                end
            end else if (state == S_MUL && state_nxt == S_DONE) begin
                cdb_data <= mul_res;
            end else if (state == S_DIV && state_nxt == S_DONE) begin
                cdb_data <= div_res;
            end
        end
    end

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Directed bench for md_seq_ctrl with a behavioural fixed-latency multiplier/divider.
module tb_md_seq_ctrl;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        iss_valid = 1'b0;
    logic        iss_ready;
    logic [2:0]  iss_funct3 = 3'd0;
    logic [31:0] iss_rs1 = 32'd0;
    logic [31:0] iss_rs2 = 32'd0;
    logic [5:0]  iss_pd = 6'd0;
    logic [4:0]  iss_rob = 5'd0;
    logic        mul_start, div_start;
    logic [31:0] dp_a, dp_b;
    logic        dp_tc;
    logic        mul_complete = 1'b0;
    logic [63:0] mul_product = 64'd0;
    logic        div_complete = 1'b0;
    logic [31:0] div_quotient = 32'd0;
    logic [31:0] div_remainder = 32'd0;
    logic        cdb_valid;
    logic        cdb_ready = 1'b0;
    logic [5:0]  cdb_pd;
    logic [4:0]  cdb_rob;
    logic [31:0] cdb_data;

    int n_cmp = 0;
    int n_err = 0;
    int mul_cnt = 0;
    int div_cnt = 0;
    int mul_starts = 0;
    int div_starts = 0;

    md_seq_ctrl #(.PRF_IDX_W(6), .ROB_IDX_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_funct3(iss_funct3),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_pd(iss_pd), .iss_rob(iss_rob),
        .mul_start(mul_start), .div_start(div_start),
        .dp_a(dp_a), .dp_b(dp_b), .dp_tc(dp_tc),
        .mul_complete(mul_complete), .mul_product(mul_product),
        .div_complete(div_complete), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
        .cdb_pd(cdb_pd), .cdb_rob(cdb_rob), .cdb_data(cdb_data)
    );

    always #5 clk = ~clk;

    // Datapath: complete pulses LAT cycles after the start cycle.
    always @(negedge clk) begin
        mul_complete = 1'b0;
        div_complete = 1'b0;
        if (mul_cnt > 0) begin
            mul_cnt--;
            if (mul_cnt == 0) mul_complete = 1'b1;
        end
        if (div_cnt > 0) begin
            div_cnt--;
            if (div_cnt == 0) div_complete = 1'b1;
        end
        if (mul_start) begin
            mul_starts++;
            mul_cnt = MUL_LAT;
            if (dp_tc) mul_product = $signed({{32{dp_a[31]}}, dp_a}) * $signed({{32{dp_b[31]}}, dp_b});
            else       mul_product = {32'd0, dp_a} * {32'd0, dp_b};
        end
        if (div_start) begin
            div_starts++;
            div_cnt = DIV_LAT;
            if (dp_b == 32'd0) begin
                div_quotient  = 32'hFFFF_FFFF;
                div_remainder = dp_a;
            end else if (dp_tc) begin
                div_quotient  = $signed(dp_a) / $signed(dp_b);
                div_remainder = $signed(dp_a) % $signed(dp_b);
            end else begin
                div_quotient  = dp_a / dp_b;
                div_remainder = dp_a % dp_b;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after accept.
    task automatic issue(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] pd, input logic [4:0] rob);
        iss_valid  = 1'b1;
        iss_funct3 = f3;
        iss_rs1    = a;
        iss_rs2    = b;
        iss_pd     = pd;
        iss_rob    = rob;
        #1 check({tag, "_iss_ready"}, 64'(iss_ready), 64'd1);
        @(negedge clk);
        iss_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] pd, input logic [4:0] rob,
                          input logic [31:0] exp_data, input int exp_lat, input logic exp_tc,
                          input logic [31:0] exp_a, input logic special);
        int m0  = mul_starts;
        int d0  = div_starts;
        int lat = 1;
        issue(tag, f3, a, b, pd, rob);
        if (!special) begin
            check({tag, "_start"}, 64'(f3[2] ? div_start : mul_start), 64'd1);
            check({tag, "_tc"}, 64'(dp_tc), 64'(exp_tc));
            check({tag, "_dp_a"}, 64'(dp_a), 64'(exp_a));
        end
        while (!cdb_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_data"}, 64'(cdb_data), 64'(exp_data));
        check({tag, "_pd"}, 64'(cdb_pd), 64'(pd));
        check({tag, "_rob"}, 64'(cdb_rob), 64'(rob));
        check({tag, "_mul_starts"}, 64'(mul_starts - m0), 64'(!special && !f3[2]));
        check({tag, "_div_starts"}, 64'(div_starts - d0), 64'(!special && f3[2]));
        cdb_ready = 1'b1;
        @(negedge clk);
        cdb_ready = 1'b0;
        check({tag, "_release"}, 64'(cdb_valid), 64'd0);
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        check("rst_mul_start", 64'(mul_start), 64'd0);
        check("rst_div_start", 64'(div_start), 64'd0);
        check("rst_dp", 64'({dp_a, dp_b}), 64'd0);
        check("rst_dp_tc", 64'(dp_tc), 64'd0);
        check("rst_cdb_fields", 64'({cdb_pd, cdb_rob, cdb_data}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_iss_ready", 64'(iss_ready), 64'd1);

        run_op("mul",     3'b000, 32'd7,         32'hFFFF_FFFD, 6'd5,  5'd9,  32'hFFFF_FFEB, 5, 1'b1, 32'd7,         1'b0);
        run_op("mulhsu",  3'b010, 32'hFFFF_FFFF, 32'd2,         6'd6,  5'd10, 32'hFFFF_FFFF, 5, 1'b0, 32'd1,         1'b0);
        run_op("mulhsu2", 3'b010, 32'd5,         32'hFFFF_FFFF, 6'd7,  5'd11, 32'd4,         5, 1'b0, 32'd5,         1'b0);
        run_op("mulhu",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd8,  5'd12, 32'hFFFF_FFFE, 5, 1'b0, 32'hFFFF_FFFF, 1'b0);
        run_op("mulh",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd9,  5'd13, 32'd0,         5, 1'b1, 32'hFFFF_FFFF, 1'b0);
        run_op("div",     3'b100, 32'hFFFF_FFF9, 32'd2,         6'd10, 5'd14, 32'hFFFF_FFFD, 5, 1'b1, 32'hFFFF_FFF9, 1'b0);
        run_op("rem",     3'b110, 32'hFFFF_FFF9, 32'd2,         6'd11, 5'd15, 32'hFFFF_FFFF, 5, 1'b1, 32'hFFFF_FFF9, 1'b0);
        run_op("divu",    3'b101, 32'd100,       32'd7,         6'd12, 5'd16, 32'd14,        5, 1'b0, 32'd100,       1'b0);
        run_op("remu",    3'b111, 32'd100,       32'd7,         6'd13, 5'd17, 32'd2,         5, 1'b0, 32'd100,       1'b0);
        run_op("divu_z",  3'b101, 32'd5,         32'd0,         6'd14, 5'd18, 32'hFFFF_FFFF, 1, 1'b0, 32'd0,         1'b1);
        run_op("div_z",   3'b100, 32'hFFFF_FFF9, 32'd0,         6'd15, 5'd19, 32'hFFFF_FFFF, 1, 1'b0, 32'd0,         1'b1);
        run_op("remu_z",  3'b111, 32'h1234,      32'd0,         6'd16, 5'd20, 32'h1234,      1, 1'b0, 32'd0,         1'b1);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 6'd17, 5'd21, 32'd0,         1, 1'b0, 32'd0,         1'b1);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 6'd18, 5'd22, 32'h8000_0000, 1, 1'b0, 32'd0,         1'b1);

        // Flush one cycle after the divider starts, held two cycles; divider finishes afterwards.
        d0 = div_starts;
        issue("drain", 3'b100, 32'd20, 32'd3, 6'd1, 5'd1);
        check("drain_start", 64'(div_start), 64'd1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        check("drain_ready_a", 64'(iss_ready), 64'd0);
        check("drain_valid_a", 64'(cdb_valid), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        check("drain_ready_b", 64'(iss_ready), 64'd0);
        check("drain_valid_b", 64'(cdb_valid), 64'd0);
        @(negedge clk);
        check("drain_ready_c", 64'(iss_ready), 64'd1);
        check("drain_valid_c", 64'(cdb_valid), 64'd0);
        check("drain_starts", 64'(div_starts - d0), 64'd1);
        repeat (3) @(negedge clk);
        check("drain_no_valid", 64'(cdb_valid), 64'd0);

        // Flush and offer in the same cycle: flush wins.
        iss_valid = 1'b1; iss_funct3 = 3'b000; iss_rs1 = 32'd2; iss_rs2 = 32'd3; flush = 1'b1;
        @(negedge clk);
        iss_valid = 1'b0; flush = 1'b0;
        check("flush_acc_start", 64'(mul_start), 64'd0);
        check("flush_acc_ready", 64'(iss_ready), 64'd1);
        check("flush_acc_valid", 64'(cdb_valid), 64'd0);

        // Flush in DONE drops the result.
        issue("flush_done", 3'b101, 32'd9, 32'd0, 6'd2, 5'd2);
        check("flush_done_v0", 64'(cdb_valid), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_done_v1", 64'(cdb_valid), 64'd0);

        // Back-pressure for four cycles, then back-to-back accept.
        issue("hold", 3'b000, 32'd3, 32'd4, 6'h2A, 5'h11);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("hold_valid", 64'(cdb_valid), 64'd1);
            check("hold_fields", 64'({cdb_pd, cdb_rob, cdb_data}), 64'({6'h2A, 5'h11, 32'd12}));
            check("hold_ready", 64'(iss_ready), 64'd0);
            @(negedge clk);
        end
        cdb_ready = 1'b1;
        issue("b2b", 3'b101, 32'd5, 32'd0, 6'd3, 5'd4);
        cdb_ready = 1'b0;
        check("b2b_valid", 64'(cdb_valid), 64'd1);
        check("b2b_fields", 64'({cdb_pd, cdb_rob, cdb_data}), 64'({6'd3, 5'd4, 32'hFFFF_FFFF}));
        cdb_ready = 1'b1;
        @(negedge clk);
        cdb_ready = 1'b0;

        // Reset mid-operation abandons the op.
        issue("rst_mid", 3'b000, 32'd6, 32'd7, 6'd4, 5'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_dp", 64'({dp_a, dp_b}), 64'd0);
        check("rst_mid_valid", 64'(cdb_valid), 64'd0);
        check("rst_mid_ready", 64'(iss_ready), 64'd1);
        repeat (5) @(negedge clk);
        check("rst_mid_quiet", 64'(cdb_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
